gf2m_inv_itoh: RTL and testbench

- Parametrised GF(2^M) inverter using the Itoh-Tsujii method.
- Generic successor of the fixed GF(2^571) inverter. The addition chain is derived at run time from the bits of M-1, so any M and any reduction polynomial is supported.
- Has an internal combinational squarer. Multiplication goes through an external request/valid port so the inverter can share the point-arithmetic multiplier.
- Adds busy/err status and a zero-input trap.

---
 rtl/gf2m_inv_itoh.sv | 159 +++++++++++++++
 tb/tb_gf2m_inv_itoh.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gf2m_inv_itoh.sv
// Itoh-Tsujii inverter over GF(2^M): addition chain walked over the bits of M-1,
// internal squarer, multiplications delegated to a shared external multiplier.
module gf2m_inv_itoh #(
    parameter int unsigned    M    = 571,
    parameter logic [M-1:0]   POLY = 'h425,
    parameter int unsigned    CW   = $clog2(M) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] a,
    output logic [M-1:0] inv,
    output logic         done,
    output logic         busy,
    output logic         err,
    output logic         mul_req,
    output logic [M-1:0] mul_a,
    output logic [M-1:0] mul_b,
    input  logic         mul_valid,
    input  logic [M-1:0] mul_res
);

    localparam logic [CW-1:0]  M1    = CW'(M - 1);
    localparam int unsigned    MSB   = $clog2(M) - 1;
    localparam logic [CW-1:0]  I0    = CW'(MSB - 1);
    localparam logic [2*M-2:0] FPOLY = {{(M-2){1'b0}}, 1'b1, POLY};

    typedef enum logic [2:0] {IDLE, CHK, SQR, MREQ, MWAIT, FIN, DONE} state_t;

    state_t          state, state_n;
    logic [M-1:0]    a_r, beta, bsave, sq_out;
    logic [2*M-2:0]  sq_wide;
    logic [CW-1:0]   k, s, i, m1_sh;
    logic            add_step;

    always_comb begin
        sq_wide = '0;
        for (int unsigned j = 0; j < M; j++) begin
            sq_wide[2*j] = beta[j];
        end
        // fold from the top so bits raised by earlier reductions are caught too
        for (int unsigned j = 2*M-2; j >= M; j--) begin
            if (sq_wide[j]) begin
                sq_wide = sq_wide ^ (FPOLY << (j - M));
            end
        end
        sq_out = sq_wide[M-1:0];
    end

    always_comb begin
        m1_sh = M1 >> i;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (start) state_n = CHK;
            CHK: begin
                if (a_r == '0)     state_n = DONE;
                else if (MSB == 0) state_n = FIN;
                else               state_n = SQR;
            end
            SQR:   if (s == CW'(1)) state_n = MREQ;
            MREQ:  state_n = MWAIT;
            MWAIT: begin
                if (mul_valid) begin
                    if (!add_step && m1_sh[0]) state_n = SQR;
                    else if (i == '0)          state_n = FIN;
                    else                       state_n = SQR;
                end
            end
            FIN:   state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            inv      <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            mul_req  <= 1'b0;
            mul_a    <= '0;
            mul_b    <= '0;
            a_r      <= '0;
            beta     <= '0;
            bsave    <= '0;
            k        <= '0;
            s        <= '0;
            i        <= '0;
            add_step <= 1'b0;
        end else begin
            state   <= state_n;
            done    <= (state_n == DONE);
            busy    <= (state_n != IDLE);
            mul_req <= (state_n == MREQ);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r  <= a;
                        beta <= a;
                    end
                end
                CHK: begin
                    bsave    <= a_r;
                    k        <= CW'(1);
                    s        <= CW'(1);
                    i        <= I0;
                    add_step <= 1'b0;
                    if (a_r == '0) begin
                        inv <= '0;
                        err <= 1'b1;
                    end
                end
                SQR: begin
                    beta <= sq_out;
                    s    <= s - 1'b1;
                    if (s == CW'(1)) begin
                        mul_a <= sq_out;
                        mul_b <= add_step ? a_r : bsave;
                    end
                end
                MWAIT: begin
                    if (mul_valid) begin
                        beta <= mul_res;
                        if (add_step) begin
                            k        <= k + 1'b1;
                            add_step <= 1'b0;
                            if (i != '0) begin
                                i     <= i - 1'b1;
                                s     <= k + 1'b1;
                                bsave <= mul_res;
                            end
                        end else begin
                            k <= k << 1;
                            if (m1_sh[0]) begin
                                add_step <= 1'b1;
                                s        <= CW'(1);
                            end else if (i != '0) begin
                                i     <= i - 1'b1;
                                s     <= k << 1;
                                bsave <= mul_res;
                            end
                        end
                    end
                end
                FIN: begin
                    inv <= sq_out;
                    err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gf2m_inv_itoh.sv
// Directed bench for gf2m_inv_itoh: GF(2^571) default instance and a GF(2^5) instance,
// each served by a fixed-latency multiplier responder.
module tb_gf2m_inv_itoh;

    logic         clk = 1'b0;
    logic         rst;
    always #5 clk = ~clk;

    logic         b_start, b_done, b_busy, b_err, b_mul_req, b_mul_valid;
    logic [570:0] b_a, b_inv, b_mul_a, b_mul_b, b_mul_res;
    logic         s_start, s_done, s_busy, s_err, s_mul_req, s_mul_valid;
    logic [4:0]   s_a, s_inv, s_mul_a, s_mul_b, s_mul_res;

    gf2m_inv_itoh u_big (
        .clk(clk), .rst(rst), .start(b_start), .a(b_a), .inv(b_inv), .done(b_done),
        .busy(b_busy), .err(b_err), .mul_req(b_mul_req), .mul_a(b_mul_a), .mul_b(b_mul_b),
        .mul_valid(b_mul_valid), .mul_res(b_mul_res)
    );

    gf2m_inv_itoh #(.M(5), .POLY(5'h05)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .a(s_a), .inv(s_inv), .done(s_done),
        .busy(s_busy), .err(s_err), .mul_req(s_mul_req), .mul_a(s_mul_a), .mul_b(s_mul_b),
        .mul_valid(s_mul_valid), .mul_res(s_mul_res)
    );

    int unsigned n_cmp = 0, n_err = 0;
    int unsigned b_lat = 3, s_lat = 3, b_nreq = 0, s_nreq = 0, b_ovl = 0, s_ovl = 0;
    int unsigned b_cnt = 0, s_cnt = 0;
    bit           b_pend = 0, s_pend = 0;
    logic [570:0] b_res, s_res;

    function automatic logic [570:0] gf_mul(input logic [570:0] x, input logic [570:0] y,
                                            input int m, input logic [570:0] p);
        logic [571:0] r;
        r = '0;
        for (int n = m - 1; n >= 0; n--) begin
            r = r << 1;
            if (r[m]) r = r ^ ((572'(1) << m) | {1'b0, p});
            if (y[n]) r = r ^ {1'b0, x};
        end
        return r[570:0];
    endfunction

    task automatic check(input string tag, input logic [570:0] got, input logic [570:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // multiplier responders: product returned lat cycles after the request cycle
    initial begin
        b_mul_valid = 1'b0; b_mul_res = '0; s_mul_valid = 1'b0; s_mul_res = '0;
        forever begin
            @(negedge clk);
            b_mul_valid = 1'b0;
            s_mul_valid = 1'b0;
            if (b_pend) begin
                b_cnt--;
                if (b_cnt == 0) begin b_mul_valid = 1'b1; b_mul_res = b_res; b_pend = 0; end
            end
            if (s_pend) begin
                s_cnt--;
                if (s_cnt == 0) begin s_mul_valid = 1'b1; s_mul_res = s_res[4:0]; s_pend = 0; end
            end
            if (b_mul_req) begin
                if (b_pend) b_ovl++;
                b_pend = 1; b_cnt = b_lat; b_nreq++;
                b_res = gf_mul(b_mul_a, b_mul_b, 571, 571'h425);
            end
            if (s_mul_req) begin
                if (s_pend) s_ovl++;
                s_pend = 1; s_cnt = s_lat; s_nreq++;
                s_res = gf_mul({566'b0, s_mul_a}, {566'b0, s_mul_b}, 5, 571'h5);
            end
        end
    end

    task automatic run_inv(input bit big, input logic [570:0] av, input int unsigned lat,
                           input int unsigned poke, output logic [570:0] r_inv, output logic r_err,
                           output int unsigned cyc, output int unsigned nreq);
        bit seen;
        @(negedge clk);
        if (big) begin b_lat = lat; b_nreq = 0; b_a = av; b_start = 1'b1; end
        else     begin s_lat = lat; s_nreq = 0; s_a = av[4:0]; s_start = 1'b1; end
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
            b_start = 1'b0;
            s_start = 1'b0;
            if (poke != 0 && cyc == poke) begin
                if (big) begin b_start = 1'b1; b_a = ~av; end
                else     begin s_start = 1'b1; s_a = ~av[4:0]; end
            end
            seen = big ? b_done : s_done;
        end
        check("done_seen", seen, 1'b1);
        r_inv = big ? b_inv : {566'b0, s_inv};
        r_err = big ? b_err : s_err;
        nreq  = big ? b_nreq : s_nreq;
        check("busy_at_done", big ? b_busy : s_busy, 1'b1);
        @(posedge clk); #1;
        check("busy_after_done", big ? b_busy : s_busy, 1'b0);
        check("done_pulse", big ? b_done : s_done, 1'b0);
    endtask

    logic [570:0] ri, exp2;
    logic         re;
    int unsigned  cyc, nr, lat, wait_cyc;
    bit           act;

    initial begin
        rst = 1'b1;
        b_start = 1'b0; s_start = 1'b0; b_a = '0; s_a = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_big_inv", b_inv, '0);
        check("rst_big_ctl", {b_done, b_busy, b_err, b_mul_req}, '0);
        check("rst_big_mul", b_mul_a | b_mul_b, '0);
        check("rst_small_all", {s_inv, s_done, s_busy, s_err, s_mul_req, s_mul_a, s_mul_b}, '0);

        // M=571, a=1, L=3
        run_inv(1'b1, 571'h1, 3, 0, ri, re, cyc, nr);
        check("big1_inv", ri, 571'h1);
        check("big1_err", re, 1'b0);
        check("big1_lat", cyc, 624);
        check("big1_nreq", nr, 13);

        // M=571, a=x -> x^570+x^9+x^4+x
        exp2 = '0;
        exp2[570] = 1'b1; exp2[9] = 1'b1; exp2[4] = 1'b1; exp2[1] = 1'b1;
        run_inv(1'b1, 571'h2, 3, 0, ri, re, cyc, nr);
        check("bigx_inv", ri, exp2);
        check("bigx_prod", gf_mul(ri, 571'h2, 571, 571'h425), 571'h1);
        check("bigx_err", re, 1'b0);
        check("bigx_lat", cyc, 624);

        // M=5, a=x -> x^4+x
        run_inv(1'b0, 571'h2, 2, 0, ri, re, cyc, nr);
        check("smallx_inv", ri, 571'h12);
        check("smallx_lat", cyc, 12);
        check("smallx_nreq", nr, 2);

        // M=5 sweep of every nonzero element with random latency
        for (int unsigned v = 1; v < 32; v++) begin
            lat = $urandom_range(1, 8);
            run_inv(1'b0, 571'(v), lat, 0, ri, re, cyc, nr);
            check("sweep_prod", gf_mul(ri, 571'(v), 5, 571'h5), 571'h1);
            check("sweep_err", re, 1'b0);
            check("sweep_lat", cyc, 8 + 2 * lat);
        end

        // zero operand on both instances
        run_inv(1'b0, '0, 3, 0, ri, re, cyc, nr);
        check("zero_s_inv", ri, '0);
        check("zero_s_err", re, 1'b1);
        check("zero_s_lat", cyc, 2);
        check("zero_s_nreq", nr, 0);
        run_inv(1'b1, '0, 3, 0, ri, re, cyc, nr);
        check("zero_b_inv", ri, '0);
        check("zero_b_err", re, 1'b1);
        check("zero_b_lat", cyc, 2);
        check("zero_b_nreq", nr, 0);

        // reset while waiting on the 5th product; the late product must be ignored
        @(negedge clk);
        b_lat = 6; b_nreq = 0; b_a = 571'h1; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        wait_cyc = 0;
        while (b_nreq < 5 && wait_cyc < 2000) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("rst_reach5", b_nreq, 5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        act = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (b_done || b_busy || b_mul_req) act = 1'b1;
        end
        check("rst_quiet", act, 1'b0);
        check("rst_inv", b_inv, '0);
        check("rst_err", b_err, 1'b0);
        check("rst_mul_ab", b_mul_a | b_mul_b, '0);
        run_inv(1'b1, 571'h1, 3, 0, ri, re, cyc, nr);
        check("post_rst_inv", ri, 571'h1);
        check("post_rst_lat", cyc, 624);
        check("post_rst_nreq", nr, 13);

        // start pulsed with another operand while busy is ignored
        run_inv(1'b0, 571'h3, 4, 3, ri, re, cyc, nr);
        check("busy_start_inv", ri, 571'h1c);
        check("busy_start_lat", cyc, 16);
        check("busy_start_err", re, 1'b0);

        check("mul_overlap", b_ovl + s_ovl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
